prog_counter: RTL and testbench
===============================

PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 Parameter MAX_COUNTER_VALUE, default 10, terminal count; legal range 1..65535.
REQ-002 Parameter PRESCALE, default 1, enabled clock cycles per count step; legal range 1..256.
REQ-003 Local constant W SHALL equal $clog2(MAX_COUNTER_VALUE+1), the width of all count-valued ports.
REQ-004 clock_i  in  1  single clock; all state changes on its rising edge.
REQ-005 reset_i  in  1  asynchronous, active-low reset.
REQ-006 enable_i  in  1  count-step qualifier; low = pause (value and prescaler held).
REQ-007 start_i  in  1  single-cycle request to begin a count run.
REQ-008 clear_i  in  1  synchronous clear to reset values.
REQ-009 dir_i  in  1  1 = count up, 0 = count down; latched on start.
REQ-010 mode_i  in  1  0 = one-shot, 1 = auto-reload; latched on start.
REQ-011 load_i  in  1  synchronous load of load_val_i.
REQ-012 load_val_i  in  W  load value.
REQ-013 counter_val_o  out  W  current count, registered.
REQ-014 busy_o  out  1  high while in RUN.
REQ-015 finished_o  out  1  high while in DONE.
REQ-016 wrap_o  out  1  one-cycle pulse on auto-reload wrap.

Function
REQ-017 FSM SHALL have states IDLE, RUN, DONE.
REQ-018 IDLE + start_i -> RUN next cycle; counter_val_o = 0 (up) or MAX_COUNTER_VALUE (down); dir/mode latched; prescaler cleared.
REQ-019 In RUN, prescaler SHALL advance only on cycles with enable_i high; a step occurs on the enabled cycle where prescaler equals PRESCALE-1, prescaler then returns to 0.
REQ-020 With PRESCALE=1, every enabled RUN cycle SHALL be a step.
REQ-021 Step up: value+1; step down: value-1; arithmetic at width W, never exceeding MAX_COUNTER_VALUE or going below 0.
REQ-022 One-shot: the step that reaches the terminal value (MAX up, 0 down) SHALL move FSM to DONE in the same edge; finished_o and terminal value visible together.
REQ-023 Auto-reload: a step taken at the terminal value SHALL reload the start value and pulse wrap_o for exactly that cycle; FSM stays RUN.
REQ-024 DONE SHALL hold counter_val_o; start_i in DONE -> RUN with new start value (restart).
REQ-025 start_i in RUN SHALL be ignored.
REQ-026 load_i in IDLE or RUN SHALL set counter_val_o to min(load_val_i, MAX_COUNTER_VALUE) next cycle and clear prescaler; state unchanged; ignored in DONE.
REQ-027 Priority per cycle: clear_i > load_i > start_i > step.
REQ-028 dir_i/mode_i changes outside a start cycle SHALL have no effect.
REQ-029 Load to terminal value in RUN (one-shot) SHALL not enter DONE until the next step is attempted; that step SHALL enter DONE without changing the value.

Reset
REQ-030 reset_i low SHALL immediately force IDLE, counter_val_o=0, busy_o=0, finished_o=0, wrap_o=0, prescaler=0, latched dir=up, mode=one-shot.
REQ-031 reset_i low mid-run SHALL abort the run; after release the block SHALL wait in IDLE for start_i.
REQ-032 clear_i SHALL produce the same state as reset, one cycle later, synchronously.

Structure
REQ-033 Package counter_pkg SHALL hold the state enum (IDLE/RUN/DONE) and DIR_UP/DIR_DOWN, MODE_ONESHOT/MODE_RELOAD constants.
REQ-034 Prescaler SHALL be sub-module counter_prescaler (inputs clock_i, reset_i, clear, enable; output step tick); all else in prog_counter.

Verification (MAX_COUNTER_VALUE=10, PRESCALE=1 unless stated)
REQ-035 Up one-shot, enable held, start at cycle n -> values 0..10 at n+1..n+11, finished_o high from n+11, busy_o low.
REQ-036 Down auto-reload -> 10..0 then 10 with wrap_o pulsed only in the cycle value returns to 10.
REQ-037 PRESCALE=3, up, enable toggled low 2 cycles mid-run -> value steps every 3 enabled cycles, held during pause.
REQ-038 load_i with load_val_i=15 in RUN -> counter_val_o=10; load_i and start_i together in IDLE -> loaded value, state IDLE.
REQ-039 reset_i low at value 5 in RUN -> counter_val_o=0, IDLE immediately, before next clock edge; clear_i at value 5 -> same result one edge later.

Source files
------------

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state encoding and direction/mode constants for prog_counter
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic DIR_UP       = 1'b1;
    localparam logic DIR_DOWN     = 1'b0;
    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/counter_prescaler.sv
// rtl/counter_prescaler.sv - divides enabled cycles by PRESCALE into a step tick
// The tick is combinational so the step lands on the same edge the divider wraps.
module counter_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] ONE  = PW'(1);

    logic [PW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);
    assign tick_o = enable_i && w_last;

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_cnt <= '0;
        end else if (clear_i) begin
            r_cnt <= '0;
        end else if (enable_i) begin
            r_cnt <= w_last ? '0 : r_cnt + ONE;
        end
    end

endmodule

// File: rtl/prog_counter.sv
// rtl/prog_counter.sv - programmable up/down counter with one-shot and auto-reload runs
import counter_pkg::*;

module prog_counter #(
    parameter  int MAX_COUNTER_VALUE = 10,
    parameter  int PRESCALE          = 1,
    localparam int W                 = $clog2(MAX_COUNTER_VALUE + 1)
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         enable_i,
    input  logic         start_i,
    input  logic         clear_i,
    input  logic         dir_i,
    input  logic         mode_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] counter_val_o,
    output logic         busy_o,
    output logic         finished_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] MAXV = W'(MAX_COUNTER_VALUE);
    localparam logic [W-1:0] ONE  = W'(1);

    state_t       r_state, w_state_nxt;
    logic [W-1:0] r_val, w_val_nxt, w_stepped;
    logic [W-1:0] w_term, w_origin;
    logic         r_dir, w_dir_nxt;
    logic         r_mode, w_mode_nxt;
    logic         r_wrap, w_wrap_nxt;
    logic         w_psc_clear, w_psc_enable, w_tick;

    assign w_term       = (r_dir == DIR_UP) ? MAXV : '0;
    assign w_origin     = (r_dir == DIR_DOWN) ? MAXV : '0;
    assign w_stepped    = (r_dir == DIR_UP) ? r_val + ONE : r_val - ONE;
    assign w_psc_enable = enable_i && (r_state == RUN);

    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .clear_i  (w_psc_clear),
        .enable_i (w_psc_enable),
        .tick_o   (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_val_nxt   = r_val;
        w_dir_nxt   = r_dir;
        w_mode_nxt  = r_mode;
        w_wrap_nxt  = 1'b0;
        w_psc_clear = 1'b0;
        if (clear_i) begin
            w_state_nxt = IDLE;
            w_val_nxt   = '0;
            w_dir_nxt   = DIR_UP;
            w_mode_nxt  = MODE_ONESHOT;
            w_psc_clear = 1'b1;
        end else if (load_i && (r_state != DONE)) begin
            w_val_nxt   = (load_val_i > MAXV) ? MAXV : load_val_i;
            w_psc_clear = 1'b1;
        end else if (start_i && (r_state != RUN)) begin
            w_state_nxt = RUN;
            w_val_nxt   = (dir_i == DIR_UP) ? '0 : MAXV;
            w_dir_nxt   = dir_i;
            w_mode_nxt  = mode_i;
            w_psc_clear = 1'b1;
        end else if ((r_state == RUN) && w_tick) begin
            // A step attempted while already at the terminal value (e.g. after a load)
            // either reloads or finishes without moving the value.
            if (r_val == w_term) begin
                if (r_mode == MODE_RELOAD) begin
                    w_val_nxt  = w_origin;
                    w_wrap_nxt = 1'b1;
                end else begin
                    w_state_nxt = DONE;
                end
            end else begin
                w_val_nxt = w_stepped;
                if ((r_mode == MODE_ONESHOT) && (w_stepped == w_term)) begin
                    w_state_nxt = DONE;
                end
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= IDLE;
            r_val   <= '0;
            r_dir   <= DIR_UP;
            r_mode  <= MODE_ONESHOT;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_val   <= w_val_nxt;
            r_dir   <= w_dir_nxt;
            r_mode  <= w_mode_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    assign counter_val_o = r_val;
    assign busy_o        = (r_state == RUN);
    assign finished_o    = (r_state == DONE);
    assign wrap_o        = r_wrap;

endmodule

// File: tb/tb_prog_counter.sv
// tb/tb_prog_counter.sv - checks prog_counter at PRESCALE 1 and 3 against a reference model
module tb_prog_counter;

    localparam int MAXV = 10;

    logic       clock_i = 1'b0;
    logic       reset_i = 1'b0;
    logic       enable_i = 1'b0, start_i = 1'b0, clear_i = 1'b0;
    logic       dir_i = 1'b0, mode_i = 1'b0, load_i = 1'b0;
    logic [3:0] load_val_i = 4'd0;
    logic [3:0] val0, val1;
    logic       busy0, fin0, wrap0, busy1, fin1, wrap1;

    always #5 clock_i = ~clock_i;

    prog_counter #(.MAX_COUNTER_VALUE(MAXV), .PRESCALE(1)) u_dut0 (
        .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .start_i(start_i),
        .clear_i(clear_i), .dir_i(dir_i), .mode_i(mode_i), .load_i(load_i),
        .load_val_i(load_val_i), .counter_val_o(val0), .busy_o(busy0),
        .finished_o(fin0), .wrap_o(wrap0)
    );

    prog_counter #(.MAX_COUNTER_VALUE(MAXV), .PRESCALE(3)) u_dut1 (
        .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .start_i(start_i),
        .clear_i(clear_i), .dir_i(dir_i), .mode_i(mode_i), .load_i(load_i),
        .load_val_i(load_val_i), .counter_val_o(val1), .busy_o(busy1),
        .finished_o(fin1), .wrap_o(wrap1)
    );

    // st: 0 idle, 1 running, 2 finished; pc counts enabled cycles since last step
    typedef struct {
        int st;
        int val;
        int up;
        int reload;
        int pc;
        int wrap;
    } mdl_t;

    typedef struct {
        logic st, dir, mode, en, ld, clr;
        logic [3:0] ldv;
        int ev, eb, ef, ew;
    } vec_t;

    mdl_t m0, m1;
    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic mdl_t mreset();
        mdl_t r;
        r.st = 0; r.val = 0; r.up = 1; r.reload = 0; r.pc = 0; r.wrap = 0;
        return r;
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input logic st, input logic dir,
                                   input logic mode, input logic en, input logic ld,
                                   input logic clr, input int ldv, input int psc);
        mdl_t n;
        int   tgt, origin;
        n = m;
        n.wrap = 0;
        if (clr) return mreset();
        if (ld && m.st != 2) begin
            n.val = (ldv > MAXV) ? MAXV : ldv;
            n.pc  = 0;
            return n;
        end
        if (st && m.st != 1) begin
            n.st = 1; n.up = int'(dir); n.reload = int'(mode); n.pc = 0;
            n.val = dir ? 0 : MAXV;
            return n;
        end
        if (m.st == 1 && en) begin
            n.pc = m.pc + 1;
            if (n.pc == psc) begin
                n.pc   = 0;
                tgt    = m.up ? MAXV : 0;
                origin = m.up ? 0 : MAXV;
                if (m.val == tgt) begin
                    if (m.reload != 0) begin
                        n.val = origin;
                        n.wrap = 1;
                    end else begin
                        n.st = 2;
                    end
                end else begin
                    n.val = m.val + (m.up ? 1 : -1);
                    if (m.reload == 0 && n.val == tgt) n.st = 2;
                end
            end
        end
        return n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_models();
        chk("p1.val",  int'(val0),  m0.val);
        chk("p1.busy", int'(busy0), int'(m0.st == 1));
        chk("p1.fin",  int'(fin0),  int'(m0.st == 2));
        chk("p1.wrap", int'(wrap0), m0.wrap);
        chk("p3.val",  int'(val1),  m1.val);
        chk("p3.busy", int'(busy1), int'(m1.st == 1));
        chk("p3.fin",  int'(fin1),  int'(m1.st == 2));
        chk("p3.wrap", int'(wrap1), m1.wrap);
    endtask

    task automatic cyc(input logic st, input logic dir, input logic mode, input logic en,
                       input logic ld, input logic clr, input logic [3:0] ldv);
        start_i = st; dir_i = dir; mode_i = mode; enable_i = en;
        load_i = ld; clear_i = clr; load_val_i = ldv;
        @(posedge clock_i);
        m0 = mstep(m0, st, dir, mode, en, ld, clr, int'(ldv), 1);
        m1 = mstep(m1, st, dir, mode, en, ld, clr, int'(ldv), 3);
        #1;
        cmp_models();
    endtask

    task automatic add(input logic st, input logic dir, input logic mode, input logic en,
                       input logic ld, input logic clr, input int ldv,
                       input int ev, input int eb, input int ef, input int ew);
        vec_t v;
        v.st = st; v.dir = dir; v.mode = mode; v.en = en; v.ld = ld; v.clr = clr;
        v.ldv = 4'(ldv); v.ev = ev; v.eb = eb; v.ef = ef; v.ew = ew;
        tbl.push_back(v);
    endtask

    initial begin
        int en_cnt;
        logic [10:0] en_pat;

        // Directed table for the PRESCALE=1 instance: st dir mode en ld clr ldv | val busy fin wrap
        add(1, 1, 0, 1, 0, 0, 0,  0, 1, 0, 0);
        for (int i = 1; i <= 10; i++) add(0, 0, 0, 1, 0, 0, 0, i, int'(i < 10), int'(i == 10), 0);
        add(0, 0, 1, 1, 0, 0, 0,  10, 0, 1, 0);
        add(0, 0, 0, 1, 1, 0, 7,  10, 0, 1, 0);
        add(1, 0, 1, 1, 0, 0, 0,  10, 1, 0, 0);
        for (int i = 9; i >= 0; i--) add(0, 1, 0, 1, 0, 0, 0, i, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0,  10, 1, 0, 1);
        add(0, 0, 0, 1, 0, 0, 0,  9, 1, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0,  8, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,  8, 1, 0, 0);
        add(0, 0, 0, 1, 1, 0, 15, 10, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0,  9, 1, 0, 0);
        add(0, 0, 0, 1, 0, 1, 0,  0, 0, 0, 0);
        add(1, 1, 0, 1, 1, 0, 6,  6, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0,  6, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0,  0, 1, 0, 0);
        add(0, 0, 0, 1, 1, 0, 10, 10, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,  10, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0,  10, 0, 1, 0);

        m0 = mreset();
        m1 = mreset();
        #1;
        chk("rst.val", int'(val0), 0);
        chk("rst.busy", int'(busy0), 0);
        chk("rst.fin", int'(fin0), 0);
        chk("rst.wrap", int'(wrap1), 0);
        repeat (2) @(posedge clock_i);
        #2 reset_i = 1'b1;
        cmp_models();

        foreach (tbl[i]) begin
            cyc(tbl[i].st, tbl[i].dir, tbl[i].mode, tbl[i].en, tbl[i].ld, tbl[i].clr, tbl[i].ldv);
            if (int'(val0) != tbl[i].ev || int'(busy0) != tbl[i].eb ||
                int'(fin0) != tbl[i].ef || int'(wrap0) != tbl[i].ew) begin
                n_bad++;
                $display("FAIL tbl[%0d]: got val=%0d busy=%0d fin=%0d wrap=%0d, expected val=%0d busy=%0d fin=%0d wrap=%0d",
                         i, val0, busy0, fin0, wrap0, tbl[i].ev, tbl[i].eb, tbl[i].ef, tbl[i].ew);
            end
            n_vec++;
        end

        // Enable pause with PRESCALE=3: value tracks enabled-cycle count / 3
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        en_pat = 11'b11111001111;
        en_cnt = 0;
        for (int i = 0; i < 11; i++) begin
            cyc(0, 0, 0, en_pat[i], 0, 0, 0);
            en_cnt += int'(en_pat[i]);
            chk("psc3.val", int'(val1), en_cnt / 3);
            chk("psc1.val", int'(val0), en_cnt);
        end

        // Asynchronous reset at value 5
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(1, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, 0, 0);
        chk("pre_rst.val", int'(val0), 5);
        #2 reset_i = 1'b0;
        #1;
        chk("async_rst.val", int'(val0), 0);
        chk("async_rst.busy", int'(busy0), 0);
        chk("async_rst.val3", int'(val1), 0);
        m0 = mreset();
        m1 = mreset();
        @(posedge clock_i);
        #2 reset_i = 1'b1;
        cmp_models();
        cyc(0, 0, 0, 1, 0, 0, 0);

        // Synchronous clear at value 5 takes effect only on the edge
        cyc(1, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, 0, 0);
        enable_i = 1'b1;
        clear_i  = 1'b1;
        #2;
        chk("clr_pre.val", int'(val0), 5);
        chk("clr_pre.busy", int'(busy0), 1);
        cyc(0, 0, 0, 1, 0, 1, 0);
        chk("clr.val", int'(val0), 0);
        chk("clr.busy", int'(busy0), 0);

        for (int i = 0; i < 500; i++) begin
            cyc(logic'($urandom_range(0, 99) < 12), logic'($urandom_range(0, 1)),
                logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) != 0),
                logic'($urandom_range(0, 99) < 5), logic'($urandom_range(0, 99) < 2),
                4'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
